// File: rtl/score_digit_scheduler.sv
// score_digit_scheduler
// Converts a binary score to BCD (sequential double-dabble), then walks the
// digits one per cycle through a shared single-digit 13-segment decoder that
// has one registered cycle of latency, capturing each returned pattern into a
// per-digit bank read by the score renderer.
// Optional build macro: LEADING_ZERO_BLANK_EN -- when defined, digits above the
// most significant nonzero digit are written as all-off (digit 0 always shown).
module score_digit_scheduler #(
  parameter int NUM_DIGITS = 4,
  parameter int SCORE_W    = 14
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      score_valid,
  input  logic [SCORE_W-1:0]        score,
  output logic                      busy,
  output logic [3:0]                seg_number,
  input  logic [12:0]               seg_in,
  output logic [13*NUM_DIGITS-1:0]  seg_bank,
  output logic                      update_done
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(SCORE_W + NUM_DIGITS + 2);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] MAX_SCORE = pow10(NUM_DIGITS) - 64'd1;

  // Saturate to all nines so the value always fits the displayed digits.
  function automatic logic [SCORE_W-1:0] clamp_score(input logic [SCORE_W-1:0] s);
    logic [63:0] w;
    w = 64'(s);
    if (w > MAX_SCORE) w = MAX_SCORE;
    return w[SCORE_W-1:0];
  endfunction

  // One double-dabble iteration: correct every nibble >= 5, then shift in a bit.
  function automatic logic [BCD_W-1:0] dabble_step(input logic [BCD_W-1:0] b,
                                                   input logic bit_in);
    logic [BCD_W-1:0] t;
    t = b;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (t[4*k +: 4] >= 4'd5) t[4*k +: 4] = t[4*k +: 4] + 4'd3;
    end
    return {t[BCD_W-2:0], bit_in};
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // Bit k set when digit k lies above the most significant nonzero digit.
  function automatic logic [NUM_DIGITS-1:0] blank_mask(input logic [BCD_W-1:0] b);
    logic [NUM_DIGITS-1:0] m;
    logic                  seen;
    m    = '0;
    seen = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (b[4*k +: 4] != 4'd0) seen = 1'b1;
      m[k] = ~seen;
    end
    return m;
  endfunction
`endif

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_FEED, S_DONE} state_t;

  state_t                   state_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     pend_q;
  logic [3:0]               seg_number_q;
  logic [13*NUM_DIGITS-1:0] seg_bank_q;
  logic [SCORE_W-1:0]       bin_q;
  logic [BCD_W-1:0]         bcd_q;
  logic [SCORE_W-1:0]       pend_score_q;

  logic [BCD_W-1:0]         bcd_step;
  logic                     last_conv;
  logic                     last_feed;
  logic                     load_new;
  logic                     capture_pend;
  logic [SCORE_W-1:0]       load_value;
  logic [3:0]               next_digit;
  logic [12:0]              bank_wr [NUM_DIGITS];

  assign bcd_step     = dabble_step(bcd_q, bin_q[SCORE_W-1]);
  assign last_conv    = (cnt_q == CNT_W'(SCORE_W - 1));
  assign last_feed    = (cnt_q == CNT_W'(NUM_DIGITS));
  assign load_new     = ((state_q == S_IDLE) && score_valid) ||
                        ((state_q == S_DONE) && (score_valid || pend_q));
  assign capture_pend = score_valid && ((state_q == S_CONVERT) || (state_q == S_FEED));
  // A pulse arriving in DONE is the newest request, so it wins over the pending one.
  assign load_value   = ((state_q == S_DONE) && !score_valid) ? pend_score_q
                                                              : clamp_score(score);

  // Digit to present to the decoder on the next FEED cycle (holds once all sent).
  always_comb begin
    next_digit = seg_number_q;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (cnt_q == CNT_W'(k - 1)) next_digit = bcd_q[4*k +: 4];
    end
  end

  // Pattern written into each bank slot when its decoder result returns.
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] mask;
    mask = blank_mask(bcd_q);
`endif
    for (int k = 0; k < NUM_DIGITS; k++) begin
      bank_wr[k] = seg_in;
`ifdef LEADING_ZERO_BLANK_EN
      if (mask[k]) bank_wr[k] = '0;
`endif
    end
  end

  // Control FSM with registered outputs and the segment bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pend_q       <= 1'b0;
      seg_number_q <= '0;
      seg_bank_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (capture_pend) pend_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (score_valid) begin
            state_q <= S_CONVERT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_CONVERT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_conv) begin
            state_q      <= S_FEED;
            cnt_q        <= '0;
            seg_number_q <= bcd_step[3:0];
          end
        end
        S_FEED: begin
          cnt_q        <= cnt_q + CNT_W'(1);
          seg_number_q <= next_digit;
          for (int k = 0; k < NUM_DIGITS; k++) begin
            if (cnt_q == CNT_W'(k + 1)) seg_bank_q[13*k +: 13] <= bank_wr[k];
          end
          if (last_feed) begin
            state_q <= S_DONE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          pend_q <= 1'b0;
          if (load_new) begin
            state_q <= S_CONVERT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Conversion datapath and pending score; no reset needed, loaded before use.
  always_ff @(posedge clk) begin
    if (load_new) begin
      bin_q <= load_value;
      bcd_q <= '0;
    end else if (state_q == S_CONVERT) begin
      bin_q <= {bin_q[SCORE_W-2:0], 1'b0};
      bcd_q <= bcd_step;
    end
    if (capture_pend) pend_score_q <= clamp_score(score);
  end

  assign busy        = busy_q;
  assign update_done = done_q;
  assign seg_number  = seg_number_q;
  assign seg_bank    = seg_bank_q;

endmodule

// File: tb/tb_score_digit_scheduler.sv
// Self-checking bench for score_digit_scheduler with a registered decoder model.
module tb_score_digit_scheduler;

  localparam int ND   = 4;
  localparam int SW   = 14;
  localparam int LAT  = SW + ND + 2;

  logic              clk;
  logic              reset;
  logic              score_valid;
  logic [SW-1:0]     score;
  logic              busy;
  logic [3:0]        seg_number;
  logic [12:0]       seg_in;
  logic [13*ND-1:0]  seg_bank;
  logic              update_done;

  int total;
  int bad;

  score_digit_scheduler #(.NUM_DIGITS(ND), .SCORE_W(SW)) dut (
    .clk(clk), .reset(reset), .score_valid(score_valid), .score(score),
    .busy(busy), .seg_number(seg_number), .seg_in(seg_in),
    .seg_bank(seg_bank), .update_done(update_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] dec(input logic [3:0] d);
    case (d)
      4'd0: return 13'b1111111111110;
      4'd1: return 13'h0006;
      4'd2: return 13'h005B;
      4'd3: return 13'h004F;
      4'd4: return 13'b1111111011101;
      4'd5: return 13'h006D;
      4'd6: return 13'h007D;
      4'd7: return 13'h0007;
      4'd8: return 13'h007F;
      4'd9: return 13'b1111111011111;
      default: return 13'h1555;
    endcase
  endfunction

  // Shared decoder: one registered cycle of latency.
  always @(posedge clk) seg_in <= dec(seg_number);

  function automatic int unsigned p10(input int k);
    int unsigned p;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  function automatic int unsigned clampv(input int unsigned s);
    return (s >= p10(ND)) ? p10(ND) - 1 : s;
  endfunction

  function automatic logic [3:0] dig(input int unsigned s, input int k);
    return 4'((clampv(s) / p10(k)) % 10);
  endfunction

  function automatic logic [13*ND-1:0] model_bank(input int unsigned s);
    logic [13*ND-1:0] b;
    logic [12:0]      pat;
    b = '0;
    for (int k = 0; k < ND; k++) begin
      pat = dec(dig(s, k));
`ifdef LEADING_ZERO_BLANK_EN
      if (k > 0 && clampv(s) < p10(k)) pat = '0;
`endif
      b[13*k +: 13] = pat;
    end
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic seen_bad;
    reset = 1'b1; score_valid = 1'b0; score = '0;
    repeat (3) tick();
    total++;
    if ({busy, update_done, seg_number, seg_bank} !== '0) begin
      bad++;
      $display("FAIL reset_values: got busy=%b done=%b num=%h bank=%h, want all 0",
               busy, update_done, seg_number, seg_bank);
    end
    reset = 1'b0;
    seen_bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (busy !== 1'b0 || update_done !== 1'b0 || seg_bank !== '0) seen_bad = 1'b1;
    end
    total++;
    if (seen_bad) begin
      bad++;
      $display("FAIL idle_quiet: got busy/done/bank activity while idle, want none");
    end
  endtask

  // One full update: pulse at edge 0, follow it to update_done and check it all.
  task automatic run_update(input int unsigned s);
    logic [13*ND-1:0] prev;
    int cyc, done_cyc;
    logic busy_bad, bank_bad;
    prev = seg_bank;
    score = SW'(s); score_valid = 1'b1;
    tick();
    score_valid = 1'b0;
    cyc = 1; done_cyc = 0; busy_bad = 1'b0; bank_bad = 1'b0;
    while (cyc <= 3 * LAT && done_cyc == 0) begin
      if (update_done === 1'b1) done_cyc = cyc;
      else begin
        if (busy !== 1'b1) busy_bad = 1'b1;
        if (cyc <= SW && seg_bank !== prev) bank_bad = 1'b1;
        if (cyc >= SW + 1 && cyc <= SW + ND) begin
          total++;
          if (seg_number !== dig(s, cyc - SW - 1)) begin
            bad++;
            $display("FAIL feed_digit s=%0d j=%0d: got %0d want %0d",
                     s, cyc - SW - 1, seg_number, dig(s, cyc - SW - 1));
          end
        end
        tick();
        cyc++;
      end
    end
    total++;
    if (done_cyc != LAT) begin
      bad++;
      $display("FAIL done_cycle s=%0d: got %0d want %0d (0 = timeout)", s, done_cyc, LAT);
    end
    total++;
    if (busy_bad || busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_window s=%0d: got gap=%b busy_at_done=%b, want 0/0", s, busy_bad, busy);
    end
    total++;
    if (bank_bad) begin
      bad++;
      $display("FAIL bank_hold s=%0d: got bank change during conversion, want held %h", s, prev);
    end
    total++;
    if (seg_bank !== model_bank(s)) begin
      bad++;
      $display("FAIL bank_value s=%0d: got %h want %h", s, seg_bank, model_bank(s));
    end
    tick();
    total++;
    if (update_done !== 1'b0 || seg_number !== dig(s, ND - 1) || seg_bank !== model_bank(s)) begin
      bad++;
      $display("FAIL after_done s=%0d: got done=%b num=%0d bank=%h want 0 %0d %h",
               s, update_done, seg_number, seg_bank, dig(s, ND - 1), model_bank(s));
    end
  endtask

  task automatic test_directed();
    run_update(1234);
    run_update(16383);
    run_update(7);
    run_update(0);
    run_update(9999);
    run_update(10000);
  endtask

  task automatic test_random();
    int unsigned s;
    for (int i = 0; i < 10; i++) begin
      s = (i % 3 == 0) ? $urandom_range(0, 120) : $urandom_range(0, (1 << SW) - 1);
      run_update(s);
      repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  task automatic test_back_to_back();
    int n_done;
    int d_cyc [2];
    logic [13*ND-1:0] d_bank [2];
    logic busy_restart;
    n_done = 0; busy_restart = 1'b0;
    d_cyc[0] = 0; d_cyc[1] = 0; d_bank[0] = '0; d_bank[1] = '0;
    score = SW'(100); score_valid = 1'b1;
    tick();
    for (int c = 1; c <= 70; c++) begin
      score_valid = 1'b0;
      if (c == 5) begin score = SW'(200); score_valid = 1'b1; end
      if (c == 8) begin score = SW'(300); score_valid = 1'b1; end
      if (update_done === 1'b1) begin
        if (n_done < 2) begin d_cyc[n_done] = c; d_bank[n_done] = seg_bank; end
        n_done++;
      end
      if (c == LAT + 1) busy_restart = busy;
      tick();
    end
    score_valid = 1'b0;
    total++;
    if (n_done != 2) begin
      bad++;
      $display("FAIL b2b_count: got %0d update_done pulses want 2", n_done);
    end
    total++;
    if (d_cyc[0] != LAT || d_bank[0] !== model_bank(100)) begin
      bad++;
      $display("FAIL b2b_first: got cyc=%0d bank=%h want cyc=%0d bank=%h",
               d_cyc[0], d_bank[0], LAT, model_bank(100));
    end
    total++;
    if (d_cyc[1] != 2 * LAT || d_bank[1] !== model_bank(300)) begin
      bad++;
      $display("FAIL b2b_second: got cyc=%0d bank=%h want cyc=%0d bank=%h",
               d_cyc[1], d_bank[1], 2 * LAT, model_bank(300));
    end
    total++;
    if (busy_restart !== 1'b1) begin
      bad++;
      $display("FAIL b2b_busy_restart: got %b want 1", busy_restart);
    end
  endtask

  task automatic test_reset_mid();
    logic [13*ND-1:0] prev;
    logic held_bad;
    int n_done;
    run_update(4321);
    prev = seg_bank;
    held_bad = 1'b0;
    score = SW'(5678); score_valid = 1'b1;
    tick();
    for (int c = 1; c <= 10; c++) begin
      score_valid = 1'b0;
      if (c == 5) begin score = SW'(1111); score_valid = 1'b1; end
      if (c == 10) reset = 1'b1;
      if (seg_bank !== prev || update_done !== 1'b0) held_bad = 1'b1;
      tick();
    end
    score_valid = 1'b0;
    reset = 1'b0;
    total++;
    if (held_bad) begin
      bad++;
      $display("FAIL rst_mid_hold: got bank change or done before reset, want bank %h", prev);
    end
    total++;
    if ({busy, update_done, seg_number, seg_bank} !== '0) begin
      bad++;
      $display("FAIL rst_mid_clear: got busy=%b done=%b num=%h bank=%h want all 0",
               busy, update_done, seg_number, seg_bank);
    end
    n_done = 0;
    for (int c = 0; c < 2 * LAT; c++) begin
      if (update_done === 1'b1 || busy === 1'b1) n_done++;
      tick();
    end
    total++;
    if (n_done != 0) begin
      bad++;
      $display("FAIL rst_mid_quiet: got %0d busy/done cycles want 0 (pending discarded)", n_done);
    end
    run_update(42);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    score_valid = 1'b0;
    score = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
